// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, even parity, idle gap.
// First preamble bit appears 1 cycle after accept; data_ready only in IDLE, so offers while busy are dropped.
module seq_frame_tx #(
  parameter int                        DATA_W       = 8,
  parameter int                        PREAMBLE_LEN = 3,
  parameter logic [PREAMBLE_LEN-1:0]   PREAMBLE     = 3'b101,
  parameter int                        GAP_LEN      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (DATA_W > PREAMBLE_LEN)
                         ? ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN)
                         : ((PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_shift;
  logic [PREAMBLE_LEN-1:0] r_pre;
  logic                    r_parity;
  logic                    r_serial;
  logic                    r_done;

  logic w_idle;
  logic w_accept;
  logic w_last;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle & data_valid;
  assign w_last     = (r_cnt == '0);

  assign data_ready = w_idle;
  assign busy       = ~w_idle;
  assign serial_out = r_serial;
  assign frame_done = r_done;

  // r_cnt holds the number of bits still to emit in the current state after the one on the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_pre    <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done   <= 1'b0;
          r_serial <= 1'b0;
          if (w_accept) begin
            r_shift  <= data_in;
            r_parity <= 1'b0;
            r_pre    <= PREAMBLE << 1;
            r_serial <= PREAMBLE[PREAMBLE_LEN-1];
            r_cnt    <= PRE_LOAD;
            r_state  <= S_PRE;
          end
        end

        S_PRE: begin
          if (w_last) begin
            r_serial <= r_shift[DATA_W-1];
            r_parity <= r_parity ^ r_shift[DATA_W-1];
            r_shift  <= r_shift << 1;
            r_cnt    <= DATA_LOAD;
            r_state  <= S_DATA;
          end else begin
            r_serial <= r_pre[PREAMBLE_LEN-1];
            r_pre    <= r_pre << 1;
            r_cnt    <= r_cnt - CNT_ONE;
          end
        end

        S_DATA: begin
          if (w_last) begin
            r_serial <= r_parity;
            r_state  <= S_PAR;
          end else begin
            r_serial <= r_shift[DATA_W-1];
            r_parity <= r_parity ^ r_shift[DATA_W-1];
            r_shift  <= r_shift << 1;
            r_cnt    <= r_cnt - CNT_ONE;
          end
        end

        S_PAR: begin
          r_serial <= 1'b0;
          r_cnt    <= GAP_LOAD;
          r_state  <= S_GAP;
        end

        S_GAP: begin
          r_serial <= 1'b0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        default: begin
          r_serial <= 1'b0;
          r_done   <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: directed frames plus random traffic against a bit-queue frame model.
module tb_seq_frame_tx;

  localparam int             DW        = 8;
  localparam int             PL        = 3;
  localparam logic [PL-1:0]  PRE       = 3'b101;
  localparam int             GL        = 2;
  localparam int             FRAME_LEN = PL + DW + 1 + GL;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          serial_out;
  logic          busy;
  logic          frame_done;

  int n_cmp;
  int n_err;

  // Reference model: the whole frame is queued as bits on accept and drained one per cycle.
  bit m_q[$];
  bit m_busy;
  bit m_done;
  bit m_cur;

  seq_frame_tx #(
    .DATA_W      (DW),
    .PREAMBLE_LEN(PL),
    .PREAMBLE    (PRE),
    .GAP_LEN     (GL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .serial_out(serial_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic load_frame(input logic [DW-1:0] d);
    m_q.delete();
    for (int i = PL - 1; i >= 0; i--) m_q.push_back(PRE[i]);
    for (int i = DW - 1; i >= 0; i--) m_q.push_back(d[i]);
    m_q.push_back(^d);
    for (int i = 0; i < GL; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cur  = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (!m_busy) begin
      m_done = 1'b0;
      m_cur  = 1'b0;
      if (data_valid) begin
        load_frame(data_in);
        m_busy = 1'b1;
        m_cur  = m_q.pop_front();
      end
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
    end else begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_cur  = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    check("serial", serial_out, m_cur);
    check("busy", busy, m_busy);
    check("done", frame_done, m_done);
    check("ready", data_ready, !m_busy);
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge, released after it.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_serial", serial_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ready", data_ready, 1'b1);
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] d_after,
                           input bit hold, input int pulse_at,
                           output logic [FRAME_LEN-1:0] obs, output int nb, output int nr);
    data_in    = d;
    data_valid = 1'b1;
    cyc();
    data_valid = hold;
    data_in    = d_after;
    check({tag, "_lat"}, serial_out, PRE[PL-1]);
    obs = '0;
    nb  = 0;
    nr  = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (pulse_at >= 0 && i == pulse_at) begin
        data_valid = 1'b1;
        data_in    = 8'h3C;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        data_valid = hold;
      end
      obs[FRAME_LEN-1-i] = serial_out;
      nb += int'(busy);
      nr += int'(data_ready);
      cyc();
    end
  endtask

  logic [FRAME_LEN-1:0] obs;
  int nb;
  int nr;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    model_clear();

    // T1: reset values
    #2;
    reset = 1'b1;
    #1;
    check("t1_serial", serial_out, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_done", frame_done, 1'b0);
    check("t1_ready", data_ready, 1'b1);
    cyc();
    cyc();
    reset = 1'b0;
    idle(2);

    // T2: single frame of 8'hA5
    run_frame("t2", 8'hA5, 8'h00, 1'b0, -1, obs, nb, nr);
    check("t2_bits", obs, 14'b101_10100101_0_00);
    check("t2_busy_cycles", nb, 14);
    check("t2_ready_cycles", nr, 0);
    check("t2_done15", frame_done, 1'b1);
    idle(3);

    // T3: odd-weight payload gives parity 1
    run_frame("t3", 8'h01, 8'hEE, 1'b0, -1, obs, nb, nr);
    check("t3_bits", obs, 14'b101_00000001_1_00);
    check("t3_done15", frame_done, 1'b1);
    idle(2);

    // T4: back-to-back with valid held, second accept on the frame_done cycle
    run_frame("t4a", 8'hFF, 8'h00, 1'b1, -1, obs, nb, nr);
    check("t4a_bits", obs, 14'b101_11111111_0_00);
    check("t4a_done", frame_done, 1'b1);
    check("t4a_ready", data_ready, 1'b1);
    run_frame("t4b", 8'h00, 8'h00, 1'b0, -1, obs, nb, nr);
    check("t4b_bits", obs, 14'b101_00000000_0_00);
    idle(2);

    // T5: offer while busy is ignored
    run_frame("t5", 8'hA5, 8'h00, 1'b0, 6, obs, nb, nr);
    check("t5_bits", obs, 14'b101_10100101_0_00);
    check("t5_ready_cycles", nr, 0);
    check("t5_done15", frame_done, 1'b1);
    idle(20);

    // T6: reset during DATA bit 3, then a clean frame
    data_in    = 8'hC3;
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    repeat (7) cyc();
    mid_reset();
    idle(FRAME_LEN + 3);
    run_frame("t6", 8'h5A, 8'h00, 1'b0, -1, obs, nb, nr);
    check("t6_bits", obs, 14'b101_01011010_0_00);
    check("t6_done15", frame_done, 1'b1);
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = DW'($urandom);
      if ($urandom_range(0, 299) == 0) mid_reset();
      else cyc();
    end
    idle(FRAME_LEN + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
